// File: rtl/urv_divide.sv
// urv_divide: iterative radix-2 non-restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are reduced to magnitudes on accept. The unit produces one quotient bit
// per unstalled cycle, and signs are restored in FIX. x_done_o is raised one
// unstalled cycle after DONE is entered. x_done_o is held while stalled.
module urv_divide #(
    parameter int G_FAST_SPECIAL = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_stall_i,
    input  logic        d_start_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [2:0]  d_fun_i,
    output logic        x_busy_o,
    output logic        x_done_o,
    output logic [31:0] x_rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic FAST = (G_FAST_SPECIAL != 0);

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [32:0] prem_q;      // partial remainder, two's complement
    logic [31:0] quo_q;       // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q;       // divisor magnitude
    logic        is_rem_q;
    logic        negq_q;
    logic        negr_q;
    logic        dz_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] rd_q;

    // Operand decode for the accept cycle.
    logic        sgn_d;
    logic [31:0] abs1_d;
    logic [31:0] abs2_d;
    logic        dz_d;
    logic        ovf_d;
    logic        fast_d;
    logic [31:0] special_rd_d;

    // One non-restoring step and the final correction/sign fix.
    logic [32:0] shift_d;
    logic [32:0] step_d;
    logic [31:0] rmag_d;
    logic [31:0] qres_d;
    logic [31:0] rres_d;
    logic [31:0] result_d;

    // Combinational decode, iteration step and result formation.
    always_comb begin
        sgn_d  = ~d_fun_i[0];
        abs1_d = (sgn_d && d_rs1_i[31]) ? (32'd0 - d_rs1_i) : d_rs1_i;
        abs2_d = (sgn_d && d_rs2_i[31]) ? (32'd0 - d_rs2_i) : d_rs2_i;
        dz_d   = (d_rs2_i == 32'd0);
        ovf_d  = sgn_d && (d_rs1_i == 32'h8000_0000) && (d_rs2_i == 32'hFFFF_FFFF);
        fast_d = FAST && (dz_d || ovf_d);
        if (dz_d) begin
            special_rd_d = d_fun_i[1] ? d_rs1_i : 32'hFFFF_FFFF;
        end else begin
            special_rd_d = d_fun_i[1] ? 32'd0 : 32'h8000_0000;
        end

        // Modulo-2^33 arithmetic is exact: the true step result lies in [-D, D).
        shift_d = {prem_q[31:0], quo_q[31]};
        step_d  = prem_q[32] ? (shift_d + {1'b0, dvs_q}) : (shift_d - {1'b0, dvs_q});

        rmag_d = prem_q[32] ? (prem_q[31:0] + dvs_q) : prem_q[31:0];
        qres_d = negq_q ? (32'd0 - quo_q) : quo_q;
        rres_d = negr_q ? (32'd0 - rmag_d) : rmag_d;
        if (dz_q && !is_rem_q) begin
            result_d = 32'hFFFF_FFFF;
        end else if (ovf_q) begin
            result_d = is_rem_q ? 32'd0 : 32'h8000_0000;
        end else begin
            result_d = is_rem_q ? rres_d : qres_d;
        end
    end

    // Control FSM with datapath registers; everything freezes while stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            prem_q   <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            is_rem_q <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 32'd0;
        end else if (!x_stall_i) begin
            case (state_q)
                S_IDLE: begin
                    if (d_start_i && d_fun_i[2]) begin
                        is_rem_q <= d_fun_i[1];
                        negq_q   <= sgn_d & (d_rs1_i[31] ^ d_rs2_i[31]);
                        negr_q   <= sgn_d & d_rs1_i[31];
                        dz_q     <= dz_d;
                        ovf_q    <= ovf_d;
                        prem_q   <= 33'd0;
                        quo_q    <= abs1_d;
                        dvs_q    <= abs2_d;
                        busy_q   <= 1'b1;
                        if (fast_d) begin
                            rd_q    <= special_rd_d;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= 6'd31;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prem_q <= step_d;
                    quo_q  <= {quo_q[30:0], ~step_d[32]};
                    if (cnt_q == 6'd0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                S_FIX: begin
                    rd_q    <= result_d;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x_busy_o = busy_q;
    assign x_done_o = done_q;
    assign x_rd_o   = rd_q;

endmodule

// File: tb/tb_urv_divide.sv
// Testbench for urv_divide: one fast-special and one full-iteration instance share stimulus.
module tb_urv_divide;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [2:0]  fun = 3'b101;
    logic        busy_f, done_f, busy_s, done_s;
    logic [31:0] rd_f, rd_s;

    int n_checks = 0;
    int n_errors = 0;

    urv_divide #(.G_FAST_SPECIAL(1)) u_fast (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .d_start_i(start),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .x_busy_o(busy_f), .x_done_o(done_f), .x_rd_o(rd_f)
    );

    urv_divide #(.G_FAST_SPECIAL(0)) u_slow (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .d_start_i(start),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .d_fun_i(fun),
        .x_busy_o(busy_s), .x_done_o(done_s), .x_rd_o(rd_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f[0]) begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op (called #1 after a rising edge) and wait for both done pulses.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat_f, output int lat_s,
                          output logic [31:0] res_f, output logic [31:0] res_s);
        fun = f; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat_f = -1; lat_s = -1; res_f = 32'd0; res_s = 32'd0;
        for (int k = 1; k <= 100 && (lat_f < 0 || lat_s < 0); k++) begin
            @(posedge clk); #1;
            if (lat_f < 0 && done_f) begin lat_f = k; res_f = rd_f; end
            if (lat_s < 0 && done_s) begin lat_s = k; res_s = rd_s; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int lf, ls;
        logic [31:0] xf, xs;
        run_op(f, a, b, lf, ls, xf, xs);
        check({tag, "_rd_fast"}, xf, exp);
        check({tag, "_rd_slow"}, xs, exp);
        check({tag, "_lat_fast"}, 32'(lf), is_special(f, a, b) ? 32'd1 : 32'd34);
        check({tag, "_lat_slow"}, 32'(ls), 32'd34);
    endtask

    logic [2:0]  t_fun [12] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101,
                                3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] t_a   [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                                32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b   [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd1,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};

    initial begin
        int fd_f, fd_s, hi_f, hi_s, rise_f, rise_s, hits;
        logic pd_f, pd_s;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        // Reset state
        #2;
        check("rst_busy", {30'd0, busy_f, busy_s}, 32'd0);
        check("rst_done", {30'd0, done_f, done_s}, 32'd0);
        check("rst_rd_fast", rd_f, 32'd0);
        check("rst_rd_slow", rd_s, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ops not addressed to this unit are ignored
        fun = 3'b000; rs1 = 32'd9; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignore_mul_busy", {30'd0, busy_f, busy_s}, 32'd0);

        // Directed cases
        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("dir%0d", i), t_fun[i], t_a[i], t_b[i], t_exp[i]);
        end

        // Randomized cases against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            rf = {1'b1, 2'($urandom_range(0, 3))};
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'd1;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_check($sformatf("rnd%0d", i), rf, ra, rb, ref_div(rf, ra, rb));
        end

        // Stalls mid-CALC and in DONE; stray start while busy
        fun = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fd_f = -1; fd_s = -1; hi_f = 0; hi_s = 0; rise_f = 0; rise_s = 0;
        pd_f = 1'b0; pd_s = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (done_f) begin
                hi_f++;
                if (!pd_f) rise_f++;
                if (fd_f < 0) begin fd_f = k; check("stall_rd_fast", rd_f, 32'd333); end
            end
            if (done_s) begin
                hi_s++;
                if (!pd_s) rise_s++;
                if (fd_s < 0) begin fd_s = k; check("stall_rd_slow", rd_s, 32'd333); end
            end
            pd_f = done_f; pd_s = done_s;
            if (k == 20) check("busy_mid_calc", {30'd0, busy_f, busy_s}, 32'd3);
            start = (k == 20);
            stall = (k >= 10 && k < 15) || (fd_s > 0 && k < fd_s + 2);
        end
        stall = 1'b0;
        check("stall_first_done_fast", 32'(fd_f), 32'd39);
        check("stall_first_done_slow", 32'(fd_s), 32'd39);
        check("stall_done_len_fast", 32'(hi_f), 32'd3);
        check("stall_done_len_slow", 32'(hi_s), 32'd3);
        check("stall_rises", 32'(rise_f + rise_s), 32'd2);
        check("stall_busy_end", {30'd0, busy_f, busy_s}, 32'd0);

        // Asynchronous reset during iteration 10
        fun = 3'b101; rs1 = 32'd77; rs2 = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {30'd0, busy_f, busy_s}, 32'd0);
        check("arst_done", {30'd0, done_f, done_s}, 32'd0);
        check("arst_rd_fast", rd_f, 32'd0);
        check("arst_rd_slow", rd_s, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done_f || done_s || busy_f || busy_s) hits++;
        end
        check("arst_no_done", 32'(hits), 32'd0);
        run_check("after_rst", 3'b101, 32'd9, 32'd3, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/urv_divide.md
Name: urv_divide

Overview:
- Iterative radix-2 non-restoring integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside urv_multiply, sharing the same operand and funct3 inputs and the same x_stall_i.
- Unlike the single-cycle-registered multiplier, it is a multi-cycle unit with a start/busy/done handshake toward the pipeline control.

Parameters:
- G_FAST_SPECIAL, 1, when 1 divide-by-zero and signed overflow bypass iteration and complete in 1 cycle; when 0 they run the full iteration and the same special results are forced in FIX.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- x_stall_i  in  1  pipeline stall; freezes the FSM, counter and datapath when high
- d_start_i  in  1  request a division using the operands/funct present this cycle
- d_rs1_i  in  32  dividend
- d_rs2_i  in  32  divisor
- d_fun_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
- x_busy_o  out  1  high from accept until done is consumed
- x_done_o  out  1  result valid pulse
- x_rd_o  out  32  result (quotient or remainder), registered

Behaviour:
- Reset (async, rst_n_i low): state IDLE, x_busy_o=0, x_done_o=0, x_rd_o=0, counter=0, all datapath registers 0. Reset asserted mid-operation aborts the operation with no done pulse.
- Accept condition: state IDLE, d_start_i=1, x_stall_i=0, d_fun_i[2]=1. In any other state d_start_i is ignored. d_fun_i[2]=0 is ignored (the operation is not for this unit).
- On accept, latch:
  - signed flag = !d_fun_i[0]; rem flag = d_fun_i[1];
  - |rs1| and |rs2| as 32-bit unsigned (abs applied only when the signed flag is set; abs(0x80000000)=0x80000000 unsigned);
  - neg_q = signed & (rs1[31]^rs2[31]); neg_r = signed & rs1[31].
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - CALC: 32 iterations, one per unstalled cycle, 6-bit counter counting 31 down to 0; 33-bit partial-remainder add/sub; one quotient bit per cycle.
  - FIX: final remainder correction (add divisor back if negative); apply neg_q/neg_r (two's complement); select quotient or remainder into x_rd_o.
  - DONE: x_done_o=1. Leave to IDLE on the first cycle with x_stall_i=0, so x_done_o stays high while stalled.
- Latency: accept edge E0 -> CALC for 32 edges -> FIX at E33 -> x_done_o high after E34 (34 unstalled clocks). Each stalled cycle adds exactly one.
- Special cases (G_FAST_SPECIAL=1): on accept, go IDLE->DONE with x_rd_o loaded at the accept edge; x_done_o high after E1.
  - Divisor 0: quotient 0xFFFFFFFF (DIV and DIVU), remainder = rs1 unmodified.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF with DIV/REM: quotient 0x80000000, remainder 0.
- x_busy_o = (state != IDLE), including the DONE cycle(s).
- x_rd_o holds its value until the next result load; it is not cleared on return to IDLE.
- Results must be bit-exact to the RISC-V M spec: quotient truncates toward zero; the remainder has the dividend's sign.

Test Plan:
- DIVU 100/7 -> x_rd_o=14 with x_done_o exactly 34 clocks after accept. REMU 100/7 -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3). REM -7/2 -> 0xFFFFFFFF(-1). REM 7/-2 -> 1. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV -5/0 -> 0xFFFFFFFF, REM -5/0 -> 0xFFFFFFFB; done 1 clock after accept (G_FAST_SPECIAL=1) and 34 clocks with G_FAST_SPECIAL=0, same values.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU 1000/3 with x_stall_i high for 5 cycles mid-CALC and 2 cycles in DONE:
  - x_done_o first rises at 39 clocks;
  - x_done_o stays high through the stall;
  - result 333;
  - a d_start_i pulse while busy is ignored (no second done).
- Assert rst_n_i low asynchronously at iteration 10 -> all outputs 0 immediately, no done. A new DIVU 9/3 after release -> 3.
